ad_avg_pack: RTL and testbench

Downstream consumer of the ADC head-trim stage. It takes the gated per-channel sample stream (valid plus 14-bit ADC word) and box-car averages 2^L consecutive samples. It then packs four averaged results into one 64-bit word and presents that word on a valid/ready output toward the channel FIFO/DMA path. Averaging depth and frame state are re-armed by the same `cfg_rst` pulse that re-arms the head-trim stage.

---
 rtl/ad9253_pkg.sv | 19 +
 rtl/ad_avg_acc.sv | 65 ++++++
 rtl/ad_avg_pack.sv | 84 ++++++++
 tb/tb_ad_avg_pack.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ad9253_pkg.sv
// ad9253_pkg
// Shared constants and helpers for the AD9253 capture path.
//   DW        : ADC sample width (unsigned offset-binary)
//   L_MAX     : largest supported averaging exponent (2^L_MAX samples)
//   LANE_W    : width of one packed result lane
//   LANES     : results packed into one output word
//   clamp_l() : limits a requested averaging exponent to L_MAX
package ad9253_pkg;

  localparam int DW     = 14;
  localparam int L_MAX  = 4;
  localparam int LANE_W = 16;
  localparam int LANES  = 4;

  function automatic logic [2:0] clamp_l(input logic [2:0] req);
    return (req > 3'(L_MAX)) ? 3'(L_MAX) : req;
  endfunction

endpackage

// File: rtl/ad_avg_acc.sv
// ad_avg_acc
// Box-car accumulator: sums 2^l_q consecutive valid samples and emits their
// truncated mean in the same cycle as the last sample of the group.
// Ports:
//   clk, rst_n : sample clock, asynchronous active-low reset
//   cfg_rst    : synchronous re-arm; clears state and latches avg_log2
//   avg_log2   : requested averaging exponent (clamped to L_MAX)
//   ivld/idata : input sample stream
//   res_vld    : a result is available this cycle (combinational)
//   res        : zero-extended averaged result (combinational)
module ad_avg_acc
  import ad9253_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_rst,
  input  logic [2:0]        avg_log2,
  input  logic              ivld,
  input  logic [DW-1:0]     idata,
  output logic              res_vld,
  output logic [LANE_W-1:0] res
);

  logic [DW+L_MAX-1:0] acc;
  logic [L_MAX-1:0]    scnt;
  logic [2:0]          l_q;

  logic [DW+L_MAX-1:0] sum;
  logic [DW+L_MAX-1:0] shifted;
  logic [L_MAX-1:0]    term;
  logic                last;

  // term = 2^l_q - 1, built from a mask so that l_q = L_MAX yields all ones
  // without needing a wider intermediate.
  always_comb begin
    sum     = acc + {{L_MAX{1'b0}}, idata};
    shifted = sum >> l_q;
    term    = ~({L_MAX{1'b1}} << l_q);
    last    = (scnt == term);
    res_vld = ivld && !cfg_rst && last;
    // The mean of DW-bit samples always fits in DW bits.
    res     = {{(LANE_W-DW){1'b0}}, shifted[DW-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      scnt <= '0;
      l_q  <= '0;
    end else if (cfg_rst) begin
      acc  <= '0;
      scnt <= '0;
      l_q  <= clamp_l(avg_log2);
    end else if (ivld) begin
      if (last) begin
        acc  <= '0;
        scnt <= '0;
      end else begin
        acc  <= sum;
        scnt <= scnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad_avg_pack.sv
// ad_avg_pack
// Averages the gated ADC sample stream over 2^L samples and packs four
// results into one 64-bit word presented on a single-entry valid/ready port.
// Ports:
//   clk, rst_n : sample clock, asynchronous active-low reset
//   cfg_rst    : synchronous re-arm of averaging depth and frame state
//   avg_log2   : averaging exponent L (clamped to L_MAX)
//   ivld/idata : head-trimmed sample stream
//   o_vld      : packed word valid
//   o_data     : packed word, lane 0 in [15:0] ... lane 3 in [63:48]
//   o_rdy      : downstream ready
//   overflow   : sticky, set when a completed word is dropped
module ad_avg_pack
  import ad9253_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_rst,
  input  logic [2:0]              avg_log2,
  input  logic                    ivld,
  input  logic [DW-1:0]           idata,
  output logic                    o_vld,
  output logic [LANES*LANE_W-1:0] o_data,
  input  logic                    o_rdy,
  output logic                    overflow
);

  logic                          res_vld;
  logic [LANE_W-1:0]             res;
  logic [1:0]                    lane;
  logic [LANES-1:0][LANE_W-1:0]  pack_q;
  logic                          complete;
  logic [LANES*LANE_W-1:0]       word;

  ad_avg_acc u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_rst  (cfg_rst),
    .avg_log2 (avg_log2),
    .ivld     (ivld),
    .idata    (idata),
    .res_vld  (res_vld),
    .res      (res)
  );

  // The last lane bypasses the pack register so the word is ready in the
  // same cycle the fourth result appears.
  always_comb begin
    complete = res_vld && (lane == 2'd3);
    word     = {res, pack_q[LANES-2:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      pack_q   <= '0;
      o_vld    <= 1'b0;
      o_data   <= '0;
      overflow <= 1'b0;
    end else if (cfg_rst) begin
      lane     <= '0;
      pack_q   <= '0;
      o_vld    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (res_vld) begin
        pack_q[lane] <= res;
        lane         <= lane + 2'd1;
      end
      // A completion may load into a slot being drained this same edge.
      if (complete) begin
        if (!o_vld || o_rdy) begin
          o_data <= word;
          o_vld  <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (o_vld && o_rdy) begin
        o_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad_avg_pack.sv
// tb_ad_avg_pack
// Directed self-checking bench for ad_avg_pack.
module tb_ad_avg_pack;

  logic        clk;
  logic        rst_n;
  logic        cfg_rst;
  logic [2:0]  avg_log2;
  logic        ivld;
  logic [13:0] idata;
  logic        o_vld;
  logic [63:0] o_data;
  logic        o_rdy;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  ad_avg_pack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_rst  (cfg_rst),
    .avg_log2 (avg_log2),
    .ivld     (ivld),
    .idata    (idata),
    .o_vld    (o_vld),
    .o_data   (o_data),
    .o_rdy    (o_rdy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one valid sample across a rising edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [13:0] d);
    ivld  = 1'b1;
    idata = d;
    @(posedge clk);
    #1;
    ivld  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    ivld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rearm(input logic [2:0] l);
    cfg_rst  = 1'b1;
    avg_log2 = l;
    ivld     = 1'b1;
    idata    = 14'h1FFF;
    @(posedge clk);
    #1;
    cfg_rst  = 1'b0;
    ivld     = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    cfg_rst  = 1'b0;
    avg_log2 = 3'd0;
    ivld     = 1'b0;
    idata    = '0;
    o_rdy    = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_o_vld", {63'd0, o_vld}, 64'd0);
    checkOutput("reset_o_data", o_data, 64'd0);
    checkOutput("reset_overflow", {63'd0, overflow}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through averaging
    applyStimulus(14'd1);
    applyStimulus(14'd2);
    applyStimulus(14'd3);
    checkOutput("pt_vld_before", {63'd0, o_vld}, 64'd0);
    applyStimulus(14'd4);
    checkOutput("pt_vld", {63'd0, o_vld}, 64'd1);
    checkOutput("pt_data", o_data, 64'h0004_0003_0002_0001);
    idleCycles(1);
    checkOutput("pt_drain", {63'd0, o_vld}, 64'd0);

    // Average by 4, full scale
    rearm(3'd2);
    for (int i = 0; i < 15; i++) applyStimulus(14'h3FFF);
    checkOutput("avg4_vld_before", {63'd0, o_vld}, 64'd0);
    applyStimulus(14'h3FFF);
    checkOutput("avg4_full", o_data, 64'h3FFF_3FFF_3FFF_3FFF);

    // Truncation: 47/4=11, 6/4=1, 65531/4=16382, 32/4=8
    applyStimulus(14'd10); applyStimulus(14'd11);
    applyStimulus(14'd12); applyStimulus(14'd14);
    applyStimulus(14'd0);  applyStimulus(14'd1);
    applyStimulus(14'd2);  applyStimulus(14'd3);
    applyStimulus(14'h3FFF); applyStimulus(14'h3FFF);
    applyStimulus(14'h3FFF); applyStimulus(14'h3FFE);
    for (int i = 0; i < 4; i++) applyStimulus(14'd8);
    checkOutput("avg4_trunc", o_data, 64'h0008_3FFE_0001_000B);
    idleCycles(1);

    // Clamp: request 7, expect 16 samples per lane
    rearm(3'd7);
    for (int ln = 0; ln < 4; ln++) begin
      for (int s = 0; s < 16; s++) begin
        if (ln == 3 && s == 15)
          checkOutput("clamp_no_word_63", {63'd0, o_vld}, 64'd0);
        applyStimulus(14'(14'h1000 + ln));
      end
    end
    checkOutput("clamp_vld", {63'd0, o_vld}, 64'd1);
    checkOutput("clamp_data", o_data, 64'h1003_1002_1001_1000);
    idleCycles(1);

    // Backpressure: second word dropped, first held
    rearm(3'd0);
    o_rdy = 1'b0;
    applyStimulus(14'd1); applyStimulus(14'd2);
    applyStimulus(14'd3); applyStimulus(14'd4);
    applyStimulus(14'd5); applyStimulus(14'd6);
    applyStimulus(14'd7); applyStimulus(14'd8);
    checkOutput("bp_hold_data", o_data, 64'h0004_0003_0002_0001);
    checkOutput("bp_hold_vld", {63'd0, o_vld}, 64'd1);
    checkOutput("bp_overflow", {63'd0, overflow}, 64'd1);

    // Ready coincident with completion: load, no overflow
    rearm(3'd0);
    checkOutput("rearm_clears_ovf", {63'd0, overflow}, 64'd0);
    applyStimulus(14'h11); applyStimulus(14'h12);
    applyStimulus(14'h13); applyStimulus(14'h14);
    applyStimulus(14'h21); applyStimulus(14'h22);
    applyStimulus(14'h23);
    checkOutput("co_held", o_data, 64'h0014_0013_0012_0011);
    o_rdy = 1'b1;
    applyStimulus(14'h24);
    checkOutput("co_load", o_data, 64'h0024_0023_0022_0021);
    checkOutput("co_vld", {63'd0, o_vld}, 64'd1);
    checkOutput("co_no_ovf", {63'd0, overflow}, 64'd0);

    // Mid-frame re-arm with a word pending
    o_rdy = 1'b0;
    applyStimulus(14'h111);
    applyStimulus(14'h222);
    rearm(3'd0);
    checkOutput("mf_vld", {63'd0, o_vld}, 64'd0);
    checkOutput("mf_ovf", {63'd0, overflow}, 64'd0);
    applyStimulus(14'h31); applyStimulus(14'h32);
    applyStimulus(14'h33); applyStimulus(14'h34);
    checkOutput("mf_fresh", o_data, 64'h0034_0033_0032_0031);
    checkOutput("mf_fresh_vld", {63'd0, o_vld}, 64'd1);

    // Async reset mid-accumulation
    rearm(3'd2);
    applyStimulus(14'h500);
    applyStimulus(14'h500);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_vld", {63'd0, o_vld}, 64'd0);
    checkOutput("ar_data", o_data, 64'd0);
    checkOutput("ar_ovf", {63'd0, overflow}, 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    o_rdy = 1'b1;
    applyStimulus(14'd5); applyStimulus(14'd6);
    applyStimulus(14'd7); applyStimulus(14'd8);
    checkOutput("ar_passthru", o_data, 64'h0008_0007_0006_0005);
    checkOutput("ar_passthru_vld", {63'd0, o_vld}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
